// File: rtl/pool_feeder.sv
// pool_feeder: walks a square map in sync RAM and feeds 2x2 windows to pool.
// Optional edge padding for odd maps: define POOL_FEEDER_PAD_EN.
module pool_feeder #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter int SWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SWIDTH-1:0] fea_size,
  input  logic [AWIDTH-1:0] rd_base,
  input  logic [AWIDTH-1:0] wr_base,
  output logic              mem_rd_en,
  output logic [AWIDTH-1:0] mem_rd_addr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [DWIDTH-1:0] pixel_feat0,
  output logic [DWIDTH-1:0] pixel_feat1,
  output logic [DWIDTH-1:0] pixel_feat2,
  output logic [DWIDTH-1:0] pixel_feat3,
  output logic              out_en,
  input  logic [DWIDTH-1:0] pmap,
  output logic              wr_en,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE, READ, DRAIN, DONE
  } state_t;

  localparam logic [DWIDTH-1:0] MINV =
    {1'b1, {(DWIDTH-1){1'b0}}};

  function automatic logic [SWIDTH-1:0] side_out(
    input logic [SWIDTH-1:0] w
  );
`ifdef POOL_FEEDER_PAD_EN
    logic [SWIDTH:0] t;
    t = {1'b0, w} + 1'b1;
    return t[SWIDTH:1];
`else
    return w >> 1;
`endif
  endfunction

  // Slot k of window (r,c): row 2r+k[1], column 2c+k[0].
  function automatic logic is_pad(
    input logic [SWIDTH-1:0] w,
    input logic [SWIDTH-1:0] r,
    input logic [SWIDTH-1:0] c,
    input logic [1:0]        k
  );
    return ({r, k[1]} >= {1'b0, w}) ||
           ({c, k[0]} >= {1'b0, w});
  endfunction

  function automatic logic [AWIDTH-1:0] addr_of(
    input logic [AWIDTH-1:0] base,
    input logic [SWIDTH-1:0] w,
    input logic [SWIDTH-1:0] r,
    input logic [SWIDTH-1:0] c,
    input logic [1:0]        k
  );
    logic [AWIDTH-1:0] row;
    logic [AWIDTH-1:0] col;
    row = AWIDTH'({r, k[1]});
    col = AWIDTH'({c, k[0]});
    return base + row * AWIDTH'(w) + col;
  endfunction

  state_t            st;
  logic [SWIDTH-1:0] w_q, o_q, r, c, nr, nc, wn;
  logic [AWIDTH-1:0] rb_q, wb_q;
  logic [1:0]        k, nk, cap_k;
  logic              last, cap_v, cap_pad, p1;
  logic [DWIDTH-1:0] slot0, slot1, slot2;

  assign wr_data = pmap;

  // Next window slot in row-major order, and end-of-map detect.
  always_comb begin
    nk   = k + 2'd1;
    nc   = c;
    nr   = r;
    last = 1'b0;
    if (k == 2'd3) begin
      if (c == o_q - 1'b1) begin
        nc = '0;
        nr = r + 1'b1;
        last = (r == o_q - 1'b1);
      end else begin
        nc = c + 1'b1;
      end
    end
  end

  // Control FSM, read issue, staging and fixed delay pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      w_q         <= '0;
      o_q         <= '0;
      rb_q        <= '0;
      wb_q        <= '0;
      r           <= '0;
      c           <= '0;
      k           <= '0;
      wn          <= '0;
      cap_v       <= 1'b0;
      cap_k       <= '0;
      cap_pad     <= 1'b0;
      p1          <= 1'b0;
      slot0       <= '0;
      slot1       <= '0;
      slot2       <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      pixel_feat0 <= '0;
      pixel_feat1 <= '0;
      pixel_feat2 <= '0;
      pixel_feat3 <= '0;
      out_en      <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      cap_v   <= (st == READ) && (o_q != '0);
      cap_k   <= k;
      cap_pad <= is_pad(w_q, r, c, k);
      if (cap_v) begin
        unique case (cap_k)
          2'd0: slot0 <= cap_pad ? MINV : mem_rdata;
          2'd1: slot1 <= cap_pad ? MINV : mem_rdata;
          2'd2: slot2 <= cap_pad ? MINV : mem_rdata;
          default: ;
        endcase
      end
      if (cap_v && cap_k == 2'd3) begin
        pixel_feat0 <= slot0;
        pixel_feat1 <= slot1;
        pixel_feat2 <= slot2;
        pixel_feat3 <= cap_pad ? MINV : mem_rdata;
      end
      p1     <= cap_v && (cap_k == 2'd3);
      out_en <= p1;
      wr_en  <= out_en;
      if (out_en) begin
        wr_addr <= wb_q + AWIDTH'(wn);
        wn      <= wn + 1'b1;
      end
      unique case (st)
        IDLE: begin
          if (start) begin
            st   <= READ;
            busy <= 1'b1;
            w_q  <= fea_size;
            o_q  <= side_out(fea_size);
            rb_q <= rd_base;
            wb_q <= wr_base;
            r    <= '0;
            c    <= '0;
            k    <= '0;
            wn   <= '0;
            if (side_out(fea_size) != '0) begin
              mem_rd_en   <= 1'b1;
              mem_rd_addr <= rd_base;
            end
          end
        end
        READ: begin
          if (o_q == '0) begin
            st        <= DONE;
            done      <= 1'b1;
            mem_rd_en <= 1'b0;
          end else if (last) begin
            st        <= DRAIN;
            mem_rd_en <= 1'b0;
          end else begin
            r <= nr;
            c <= nc;
            k <= nk;
            mem_rd_en <= !is_pad(w_q, nr, nc, nk);
            if (!is_pad(w_q, nr, nc, nk))
              mem_rd_addr <= addr_of(rb_q, w_q, nr, nc, nk);
          end
        end
        DRAIN: begin
          if (wr_en && !cap_v && !p1 && !out_en) begin
            st   <= DONE;
            done <= 1'b1;
          end
        end
        DONE: begin
          st   <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_feeder.sv
// tb_pool_feeder: directed bench for pool_feeder with RAM and pool models
// and a write scoreboard.
module tb_pool_feeder;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] fea_size;
  logic [AW-1:0] rd_base, wr_base;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] pf0, pf1, pf2, pf3;
  logic          out_en;
  logic [DW-1:0] pmap;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy, done;

  pool_feeder #(.DWIDTH(DW), .AWIDTH(AW), .SWIDTH(SW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .fea_size(fea_size), .rd_base(rd_base), .wr_base(wr_base),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rdata(mem_rdata),
    .pixel_feat0(pf0), .pixel_feat1(pf1),
    .pixel_feat2(pf2), .pixel_feat3(pf3),
    .out_en(out_en), .pmap(pmap),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           sb[$];
  logic [DW-1:0] ram [0:4095];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            rd_cnt = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            last_wr = 0;
  int            t0 = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_rd_addr];
  end

  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  always @(posedge clk) begin
    if (out_en) pmap <= max2(max2(pf0, pf1), max2(pf2, pf3));
  end

  always @(negedge clk) begin
    wr_t e;
    if (mem_rd_en) rd_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (wr_en) begin
      last_wr = cyc;
      chk("wr_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
  end

  function automatic int side(input int w);
`ifdef POOL_FEEDER_PAD_EN
    return (w + 1) / 2;
`else
    return w / 2;
`endif
  endfunction

  function automatic int exp_reads(input int w);
`ifdef POOL_FEEDER_PAD_EN
    return w * w;
`else
    return 4 * (w / 2) * (w / 2);
`endif
  endfunction

  task automatic push_exp(input int w, input int rb, input int wb);
    int o;
    wr_t e;
    logic [DW-1:0] m, v;
    o = side(w);
    for (int r = 0; r < o; r++) begin
      for (int c = 0; c < o; c++) begin
        m = 16'h8000;
        for (int s = 0; s < 4; s++) begin
          int y, x;
          y = 2 * r + s / 2;
          x = 2 * c + s % 2;
          if (y >= w || x >= w) v = 16'h8000;
          else v = ram[(rb + y * w + x) % 4096];
          m = max2(m, v);
        end
        e.a = AW'(wb + r * o + c);
        e.d = m;
        sb.push_back(e);
      end
    end
  endtask

  task automatic launch(input int w, input int rb, input int wb);
    push_exp(w, rb, wb);
    @(negedge clk);
    rd_cnt   = 0;
    done_cnt = 0;
    fea_size = SW'(w);
    rd_base  = AW'(rb);
    wr_base  = AW'(wb);
    start    = 1'b1;
    t0       = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int reads, input bit wr_any);
    int k;
    k = 0;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt), 32'd1);
    if (wr_any) chk("done_after_wr", 32'(done_cyc - last_wr), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("rd_count", 32'(rd_cnt), 32'(reads));
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [AW-1:0] a4 [4];
    int k;
    a4[0] = 12'd0; a4[1] = 12'd1; a4[2] = 12'd4; a4[3] = 12'd5;
    for (int i = 0; i < 4096; i++) ram[i] = DW'(i);
    rst = 1'b1;
    start = 1'b0;
    fea_size = '0;
    rd_base = '0;
    wr_base = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("rst_pf0", 32'(pf0), 32'd0);
    chk("rst_out_en", 32'(out_en), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    rst = 1'b0;

    launch(4, 0, 'h100);
    for (int i = 0; i < 4; i++) begin
      chk("w0_rd_en", 32'(mem_rd_en), 32'd1);
      chk("w0_rd_addr", 32'(mem_rd_addr), 32'(a4[i]));
      if (i < 3) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("w0_pf0", 32'(pf0), 32'd0);
    chk("w0_pf1", 32'(pf1), 32'd1);
    chk("w0_pf2", 32'(pf2), 32'd4);
    chk("w0_pf3", 32'(pf3), 32'd5);
    chk("w0_out_en_early", 32'(out_en), 32'd0);
    @(negedge clk);
    chk("w0_out_en", 32'(out_en), 32'd1);
    @(negedge clk);
    chk("w0_wr_en", 32'(wr_en), 32'd1);
    chk("w0_busy", 32'(busy), 32'd1);
    wait_done(16, 1);

    ram['h20] = 16'hfffd;
    ram['h21] = 16'hffff;
    ram['h22] = 16'hfff8;
    ram['h23] = 16'hfffe;
    launch(2, 'h20, 'h50);
    wait_done(4, 1);

    launch(5, 0, 'h180);
    wait_done(exp_reads(5), 1);

    launch(8, 0, 'h200);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rd_en", 32'(mem_rd_en), 32'd0);
    chk("abort_rd_addr", 32'(mem_rd_addr), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pf0", 32'(pf0), 32'd0);
    chk("abort_out_en", 32'(out_en), 32'd0);
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    sb.delete();
    rst = 1'b0;
    rd_cnt = 0;
    done_cnt = 0;
    repeat (40) @(negedge clk);
    chk("abort_no_rd", 32'(rd_cnt), 32'd0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    launch(4, 'h10, 'h300);
    wait_done(16, 1);

    launch(4, 0, 'h400);
    @(negedge clk);
    fea_size = 6'd2;
    wr_base  = 12'h7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("busy_done_seen", 32'(done), 32'd1);
    fea_size = 6'd2;
    rd_base  = 12'h20;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("ign_rd_count", 32'(rd_cnt), 32'd16);
    chk("ign_done_once", 32'(done_cnt), 32'd1);
    chk("ign_sb_empty", 32'(sb.size()), 32'd0);
    chk("ign_idle", 32'(busy), 32'd0);

    launch(0, 0, 'h500);
    wait_done(0, 0);
    chk("w0_done_lat", 32'(done_cyc - t0), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
